// File: rtl/fetch_stage.sv
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : MIPS instruction-fetch front end: PC, IF/ID register, redirect,
//             halt-on-wrap and a saturating retired-fetch counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
   parameter int ADDR_W       = 4,
   parameter int RESET_PC     = 0,
   parameter int HALT_ON_WRAP = 1,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   input  logic              stall,
   input  logic              flush,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   output logic [31:0]       if_id_instr,
   output logic [ADDR_W-1:0] if_id_pc,
   output logic              if_id_valid,
   output logic              halted,
   output logic [CNT_W-1:0]  fetch_count
);

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_e;

   localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_PC);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] ifpc_q, ifpc_d;
   logic              valid_q, valid_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              w_wrap_halts;
   logic              w_at_top;
   logic [ADDR_W-1:0] w_pc_inc;

   generate
      if (HALT_ON_WRAP != 0) begin : g_wrap_halt
         assign w_wrap_halts = 1'b1;
      end else begin : g_wrap_cont
         assign w_wrap_halts = 1'b0;
      end
   endgenerate

   assign w_at_top = (pc_q == {ADDR_W{1'b1}});
   assign w_pc_inc = pc_q + 1'b1;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ifpc_d  = ifpc_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_RUN: begin
            if (redirect_valid) begin
               // Word at the current PC is wrong-path: drop it.
               pc_d    = redirect_target;
               instr_d = '0;
               valid_d = 1'b0;
            end else if (flush) begin
               instr_d = '0;
               valid_d = 1'b0;
               pc_d    = w_pc_inc;
               if (w_at_top && w_wrap_halts) begin
                  state_d = S_HALT;
               end
            end else if (!stall) begin
               instr_d = imem_data;
               ifpc_d  = pc_q;
               valid_d = 1'b1;
               pc_d    = w_pc_inc;
               if (cnt_q != {CNT_W{1'b1}}) begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (w_at_top && w_wrap_halts) begin
                  state_d = S_HALT;
               end
            end
         end
         S_HALT: begin
            // Only a redirect leaves HALT; stall and flush have no effect.
            instr_d = '0;
            valid_d = 1'b0;
            if (redirect_valid) begin
               pc_d    = redirect_target;
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         pc_q    <= c_RESET_PC;
         instr_q <= '0;
         ifpc_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ifpc_q  <= ifpc_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign imem_addr   = pc_q;
   assign if_id_instr = instr_q;
   assign if_id_pc    = ifpc_q;
   assign if_id_valid = valid_q;
   assign halted      = (state_q == S_HALT);
   assign fetch_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage (directed table + random).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        rv = 1'b0;
   logic [3:0]  tgt = 4'd0;
   logic [31:0] mem [16];

   // DUT0: default parameters (halt on wrap, 16-bit counter)
   logic [3:0]  d0_addr, d0_ipc;
   logic [31:0] d0_data, d0_instr;
   logic        d0_valid, d0_halt;
   logic [15:0] d0_cnt;
   // DUT1: wrap-and-continue, 3-bit counter so saturation is reachable
   logic [3:0]  d1_addr, d1_ipc;
   logic [31:0] d1_data, d1_instr;
   logic        d1_valid, d1_halt;
   logic [2:0]  d1_cnt;

   int n_vec = 0;
   int n_bad = 0;

   assign d0_data = mem[d0_addr];
   assign d1_data = mem[d1_addr];

   always #5 clk = ~clk;

   fetch_stage #(.ADDR_W(4), .RESET_PC(0), .HALT_ON_WRAP(1), .CNT_W(16)) u_dut0 (
      .clk(clk), .rst(rst), .imem_addr(d0_addr), .imem_data(d0_data),
      .stall(stall), .flush(flush), .redirect_valid(rv), .redirect_target(tgt),
      .if_id_instr(d0_instr), .if_id_pc(d0_ipc), .if_id_valid(d0_valid),
      .halted(d0_halt), .fetch_count(d0_cnt)
   );

   fetch_stage #(.ADDR_W(4), .RESET_PC(0), .HALT_ON_WRAP(0), .CNT_W(3)) u_dut1 (
      .clk(clk), .rst(rst), .imem_addr(d1_addr), .imem_data(d1_data),
      .stall(stall), .flush(flush), .redirect_valid(rv), .redirect_target(tgt),
      .if_id_instr(d1_instr), .if_id_pc(d1_ipc), .if_id_valid(d1_valid),
      .halted(d1_halt), .fetch_count(d1_cnt)
   );

   // Reference model: one entry per DUT instance
   int          m_pc [2];
   int          m_ipc [2];
   int          m_cnt [2];
   bit          m_valid [2];
   bit          m_halt [2];
   logic [31:0] m_instr [2];
   int          m_hw [2]   = '{1, 0};
   int          m_cmax [2] = '{65535, 7};

   typedef struct {
      logic        r, s, f, v;
      int          t;
      logic [31:0] e_instr;
      int          e_ipc;
      logic        e_valid, e_halt;
      int          e_addr, e_cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, s, f, v, input int t,
                               input logic [31:0] ei, input int eipc,
                               input logic ev, eh, input int ea, ec);
      vec_t x;
      x.r = r; x.s = s; x.f = f; x.v = v; x.t = t;
      x.e_instr = ei; x.e_ipc = eipc; x.e_valid = ev; x.e_halt = eh;
      x.e_addr = ea; x.e_cnt = ec;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_step(input int k);
      if (rst) begin
         m_pc[k] = 0; m_ipc[k] = 0; m_cnt[k] = 0;
         m_valid[k] = 0; m_halt[k] = 0; m_instr[k] = 32'h0;
      end else if (m_halt[k]) begin
         m_valid[k] = 0; m_instr[k] = 32'h0;
         if (rv) begin
            m_pc[k] = int'(tgt);
            m_halt[k] = 0;
         end
      end else if (rv) begin
         m_pc[k] = int'(tgt); m_valid[k] = 0; m_instr[k] = 32'h0;
      end else if (flush || !stall) begin
         if (flush) begin
            m_valid[k] = 0; m_instr[k] = 32'h0;
         end else begin
            m_instr[k] = mem[m_pc[k]]; m_ipc[k] = m_pc[k]; m_valid[k] = 1;
            if (m_cnt[k] < m_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
         end
         if (m_pc[k] == 15 && m_hw[k] == 1) m_halt[k] = 1;
         m_pc[k] = (m_pc[k] + 1) % 16;
      end
   endtask

   task automatic cycle(input logic r, s, f, v, input int t);
      @(negedge clk);
      rst = r; stall = s; flush = f; rv = v; tgt = 4'(t);
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
   endtask

   task automatic chk_model(input int k);
      if (k == 0) begin
         chk("m0.instr", d0_instr, m_instr[0]);
         chk("m0.valid", 32'(d0_valid), 32'(m_valid[0]));
         chk("m0.halted", 32'(d0_halt), 32'(m_halt[0]));
         chk("m0.addr", 32'(d0_addr), 32'(m_pc[0]));
         chk("m0.count", 32'(d0_cnt), 32'(m_cnt[0]));
         if (m_valid[0]) chk("m0.ifpc", 32'(d0_ipc), 32'(m_ipc[0]));
      end else begin
         chk("m1.instr", d1_instr, m_instr[1]);
         chk("m1.valid", 32'(d1_valid), 32'(m_valid[1]));
         chk("m1.halted", 32'(d1_halt), 32'(m_halt[1]));
         chk("m1.addr", 32'(d1_addr), 32'(m_pc[1]));
         chk("m1.count", 32'(d1_cnt), 32'(m_cnt[1]));
         if (m_valid[1]) chk("m1.ifpc", 32'(d1_ipc), 32'(m_ipc[1]));
      end
   endtask

   initial begin
      mem[0] = 32'h20010004; mem[1] = 32'h20020008; mem[2] = 32'h00411820;
      mem[3] = 32'h00622022; mem[4] = 32'h0083282a; mem[5] = 32'hac020004;
      mem[6] = 32'h8c020004;
      for (int i = 7; i < 16; i++) mem[i] = 32'hA0000000 | 32'(i);

      // reset, then 7 free-running fetches
      tbl.push_back(mk(1,0,0,0,0, 32'h0,0,0,0, 0,0));
      for (int i = 0; i < 7; i++)
         tbl.push_back(mk(0,0,0,0,0, mem[i],i,1,0, i+1,i+1));
      // stall for 3 cycles while PC=3
      tbl.push_back(mk(1,0,0,0,0, 32'h0,0,0,0, 0,0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(0,0,0,0,0, mem[i],i,1,0, i+1,i+1));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(0,1,0,0,0, 32'h00411820,2,1,0, 3,3));
      tbl.push_back(mk(0,0,0,0,0, 32'h00622022,3,1,0, 4,4));
      // flush alone at PC=4, then delivery resumes at 5
      tbl.push_back(mk(0,0,1,0,0, 32'h0,0,0,0, 5,4));
      tbl.push_back(mk(0,0,0,0,0, 32'hac020004,5,1,0, 6,5));
      // redirect to 1 while PC=5 with stall high
      tbl.push_back(mk(0,0,0,1,5, 32'h0,0,0,0, 5,5));
      tbl.push_back(mk(0,1,0,1,1, 32'h0,0,0,0, 1,5));
      tbl.push_back(mk(0,0,0,0,0, 32'h20020008,1,1,0, 2,6));
      // run up to the top word and halt on wrap
      tbl.push_back(mk(0,0,0,1,14, 32'h0,0,0,0, 14,6));
      tbl.push_back(mk(0,0,0,0,0, mem[14],14,1,0, 15,7));
      tbl.push_back(mk(0,0,0,0,0, mem[15],15,1,1, 0,8));
      tbl.push_back(mk(0,1,0,0,0, 32'h0,0,0,1, 0,8));
      tbl.push_back(mk(0,0,1,0,0, 32'h0,0,0,1, 0,8));
      tbl.push_back(mk(0,0,0,1,2, 32'h0,0,0,0, 2,8));
      tbl.push_back(mk(0,0,0,0,0, 32'h00411820,2,1,0, 3,9));
      // reset during HALT
      tbl.push_back(mk(0,0,0,1,15, 32'h0,0,0,0, 15,9));
      tbl.push_back(mk(0,0,0,0,0, mem[15],15,1,1, 0,10));
      tbl.push_back(mk(1,0,0,0,0, 32'h0,0,0,0, 0,0));
      tbl.push_back(mk(0,0,0,0,0, mem[0],0,1,0, 1,1));
      // reset during stall
      tbl.push_back(mk(0,1,0,0,0, mem[0],0,1,0, 1,1));
      tbl.push_back(mk(1,1,0,0,0, 32'h0,0,0,0, 0,0));
      tbl.push_back(mk(0,0,0,0,0, mem[0],0,1,0, 1,1));

      repeat (2) @(posedge clk);
      foreach (tbl[i]) begin
         cycle(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].v, tbl[i].t);
         chk($sformatf("t%0d.instr", i), d0_instr, tbl[i].e_instr);
         chk($sformatf("t%0d.valid", i), 32'(d0_valid), 32'(tbl[i].e_valid));
         chk($sformatf("t%0d.halted", i), 32'(d0_halt), 32'(tbl[i].e_halt));
         chk($sformatf("t%0d.addr", i), 32'(d0_addr), 32'(tbl[i].e_addr));
         chk($sformatf("t%0d.count", i), 32'(d0_cnt), 32'(tbl[i].e_cnt));
         if (tbl[i].e_valid)
            chk($sformatf("t%0d.ifpc", i), 32'(d0_ipc), 32'(tbl[i].e_ipc));
         chk_model(1);
      end

      // randomized traffic against the reference model
      for (int n = 0; n < 600; n++) begin
         cycle($urandom_range(0, 59) == 0,
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 9) == 0,
               int'($urandom_range(0, 15)));
         chk_model(0);
         chk_model(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the MIPS datapath; sits directly upstream of the 16x32 instruction memory and downstream-feeds decode.
- Owns the program counter and drives the memory word address. Captures the combinational instruction word into an IF/ID pipeline register.
- Supports stall, flush, branch/jump redirect, halt-on-wrap, and a retired-fetch counter.

Parameters:
- ADDR_W, 4, word-address width of PC / instruction memory (16 words).
- RESET_PC, 0, word address loaded into PC on reset.
- HALT_ON_WRAP, 1, 1 = enter HALT when PC increments past (2^ADDR_W)-1; 0 = wrap to 0 and continue.
- CNT_W, 16, width of fetch counter.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- imem_addr  output  ADDR_W  word address to instruction memory (equals PC register).
- imem_data  input  32  instruction word returned combinationally for imem_addr.
- stall  input  1  hold PC and IF/ID contents this cycle.
- flush  input  1  squash IF/ID (insert bubble).
- redirect_valid  input  1  load PC from redirect_target (taken branch/jump).
- redirect_target  input  ADDR_W  new word address.
- if_id_instr  output  32  registered instruction to decode.
- if_id_pc  output  ADDR_W  word address the registered instruction was fetched from.
- if_id_valid  output  1  registered instruction is real (not a bubble).
- halted  output  1  high while in HALT state.
- fetch_count  output  CNT_W  number of instructions delivered valid into IF/ID, saturating.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Reset (rst=1 at edge), overriding everything:
  - PC=RESET_PC.
  - if_id_instr=32'h0, if_id_pc=0, if_id_valid=0.
  - state=RUN, halted=0, fetch_count=0.
  - Reset asserted mid-stall or mid-HALT behaves identically.
- imem_addr is a direct copy of the PC register. No combinational path from any input to imem_addr.
- States: RUN, HALT.
- RUN, per-edge priority (highest first):
  1. redirect_valid=1:
     - PC<=redirect_target.
     - IF/ID<=bubble (instr 0, valid 0); the word at the current PC is wrong-path.
     - Overrides stall and flush.
  2. flush=1 (no redirect):
     - IF/ID<=bubble.
     - PC advances as in normal fetch (flush does not hold PC).
  3. stall=1:
     - PC and all IF/ID fields unchanged; counter unchanged.
  4. Normal fetch:
     - if_id_instr<=imem_data, if_id_pc<=PC, if_id_valid<=1.
     - PC<=PC+1.
     - fetch_count increments.
- PC increment is modulo 2^ADDR_W.
- Wrap boundary (normal fetch or flush with PC=(2^ADDR_W)-1):
  - HALT_ON_WRAP=0: PC<=0, remain RUN.
  - HALT_ON_WRAP=1: the last word is still delivered (normal fetch case); PC<=0, state<=HALT.
- HALT:
  - halted=1.
  - Each edge: IF/ID<=bubble; PC held; stall/flush ignored.
  - redirect_valid=1: PC<=redirect_target, state<=RUN, IF/ID<=bubble. The first valid instruction appears one edge later.
- fetch_count saturates at all-ones; no wrap.
- Latency: an instruction at address A appears on if_id_instr one edge after PC=A with no stall. Steady throughput is 1 instruction/cycle.
- if_id_pc is captured alongside the instruction for branch-target/link computation downstream.

Test Plan:
- Reset then 7 free-running cycles, memory preloaded 0:20010004, 1:20020008, 2:00411820, 3:00622022, 4:0083282a, 5:ac020004, 6:8c020004.
  -> Edge n delivers those words in order; if_id_pc=0..6; valid=1 from first edge; fetch_count=7.
- stall held high 3 cycles while PC=3.
  -> if_id_instr stays 00411820 (pc 2); imem_addr stays 3; fetch_count unchanged; next free edge delivers 00622022.
- redirect_valid with target=1 while PC=5, with stall also high.
  -> Next edge: valid=0, PC=1. Following edge: if_id_instr=20020008, if_id_pc=1.
- flush alone at PC=4.
  -> valid=0, instr=0, PC=5. Next edge delivers ac020004.
- HALT_ON_WRAP=1, run to PC=15.
  -> Word 15 is delivered valid; halted=1; PC=0; subsequent edges are bubbles. redirect to 2 clears halted; 00411820 appears on the following edge.
- Assert rst during HALT and during stall.
  -> All outputs return to reset values on that edge; fetch resumes from RESET_PC.
